// File: rtl/mp_ram_pkg.sv
// Shared definitions for the multi-port RAM write arbiter.
//   state_t    : arbiter FSM states
//   PRIO_FIXED : fixed priority ordering, port 0 highest
//   PRIO_RR    : round-robin ordering starting at rr_ptr
//   ptr_w()    : width of a port index / round-robin pointer for P ports
package mp_ram_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SERIAL = 1'b1
    } state_t;

    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;

    function automatic int ptr_w(input int p);
        return (p < 2) ? 1 : $clog2(p);
    endfunction

endpackage

// File: rtl/mp_ram_write_arbiter_pick.sv
// arb_pick_next: combinational grant selection over a pending mask.
//   pending : ports still waiting for a RAM slot
//   rr_ptr  : round-robin start index (ignored when mode = 0)
//   mode    : 0 = lowest index wins, 1 = first pending at/after rr_ptr
//   grant   : one-hot grant (all zero when nothing is pending)
//   idx     : index of the granted port
module arb_pick_next
    import mp_ram_pkg::*;
#(
    parameter int P  = 3,
    parameter int PW = ptr_w(P)
) (
    input  logic [P-1:0]  pending,
    input  logic [PW-1:0] rr_ptr,
    input  logic          mode,
    output logic [P-1:0]  grant,
    output logic [PW-1:0] idx
);

    logic found;
    int   j;

    // Scan P candidates starting at the mode-dependent origin; the first
    // pending one wins. The origin offset wraps modulo P.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < P; k++) begin
            j = mode ? (int'(rr_ptr) + k) : k;
            if (j >= P) j = j - P;
            if (!found && pending[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = PW'(j);
            end
        end
    end

endmodule

// File: rtl/mp_ram_write_arbiter.sv
// mp_ram_write_arbiter: P-port write arbiter in front of a RAM cell matrix.
// Non-conflicting request sets are registered straight onto the RAM bus.
// A set containing two ports writing different data to the same address is
// latched and serialised, one grant per cycle; the first grant goes out on
// the same edge that accepts the set, so K requesters keep busy high for
// exactly K cycles and requests are sampled again on the following edge.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   wr_req/addr/data     : per-port write requests (lane i at [i*W +: W])
//   busy                 : serialising; requests are not sampled
//   wr_ack               : per-port pulse, that port's write is on the bus
//   conflict             : pulse when a conflicting set is accepted
//   ram_we/addr/wdata    : per-port RAM write lanes (addr/data hold when idle)
module mp_ram_write_arbiter
    import mp_ram_pkg::*;
#(
    parameter int P         = 3,
    parameter int ADDR_W    = 2,
    parameter int DATA_W    = 2,
    parameter int PRIO_MODE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [P-1:0]        wr_req,
    input  logic [P*ADDR_W-1:0] wr_addr,
    input  logic [P*DATA_W-1:0] wr_data,
    output logic                busy,
    output logic [P-1:0]        wr_ack,
    output logic                conflict,
    output logic [P-1:0]        ram_we,
    output logic [P*ADDR_W-1:0] ram_addr,
    output logic [P*DATA_W-1:0] ram_wdata
);

    localparam int PW = ptr_w(P);

    state_t              state, state_nx;
    logic [P-1:0]        pending, pend_nx;
    logic [PW-1:0]       rr_ptr;
    logic [P*ADDR_W-1:0] lat_addr;
    logic [P*DATA_W-1:0] lat_data;

    logic [P-1:0]        pick_in, grant;
    logic [PW-1:0]       grant_idx;
    logic [P-1:0]        we_nx;
    logic                busy_nx, conf_nx, rr_upd, use_lat;
    logic [P*ADDR_W-1:0] src_addr;
    logic [P*DATA_W-1:0] src_data;

    // Pairwise conflict matrix; only the upper triangle is meaningful.
    logic [P-1:0][P-1:0] pair_conf;
    logic                conflict_any;

    for (genvar i = 0; i < P; i++) begin : g_row
        for (genvar k = 0; k < P; k++) begin : g_col
            if (k > i) begin : g_pair
                assign pair_conf[i][k] = wr_req[i] && wr_req[k]
                    && (wr_addr[i*ADDR_W +: ADDR_W] == wr_addr[k*ADDR_W +: ADDR_W])
                    && (wr_data[i*DATA_W +: DATA_W] != wr_data[k*DATA_W +: DATA_W]);
            end else begin : g_none
                assign pair_conf[i][k] = 1'b0;
            end
        end
    end

    assign conflict_any = |pair_conf;

    // In IDLE the picker sees the fresh request set so the first grant of a
    // conflict can leave on the accepting edge.
    assign pick_in = (state == IDLE) ? wr_req : pending;

    arb_pick_next #(.P(P), .PW(PW)) u_pick (
        .pending (pick_in),
        .rr_ptr  (rr_ptr),
        .mode    (PRIO_MODE == PRIO_RR),
        .grant   (grant),
        .idx     (grant_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        pend_nx  = pending;
        we_nx    = '0;
        busy_nx  = 1'b0;
        conf_nx  = 1'b0;
        rr_upd   = 1'b0;
        use_lat  = 1'b0;
        case (state)
            IDLE: begin
                if (conflict_any) begin
                    we_nx   = grant;
                    pend_nx = wr_req & ~grant;
                    busy_nx = 1'b1;
                    conf_nx = 1'b1;
                    rr_upd  = 1'b1;
                    if (pend_nx != '0) state_nx = SERIAL;
                end else begin
                    we_nx = wr_req;
                end
            end
            SERIAL: begin
                we_nx   = grant;
                pend_nx = pending & ~grant;
                busy_nx = 1'b1;
                rr_upd  = 1'b1;
                use_lat = 1'b1;
                if (pend_nx == '0) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign src_addr = use_lat ? lat_addr : wr_addr;
    assign src_data = use_lat ? lat_data : wr_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= '0;
            rr_ptr    <= '0;
            lat_addr  <= '0;
            lat_data  <= '0;
            busy      <= 1'b0;
            wr_ack    <= '0;
            conflict  <= 1'b0;
            ram_we    <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            pending  <= pend_nx;
            busy     <= busy_nx;
            conflict <= conf_nx;
            ram_we   <= we_nx;
            wr_ack   <= we_nx;
            if (state == IDLE && conflict_any) begin
                lat_addr <= wr_addr;
                lat_data <= wr_data;
            end
            if (rr_upd && PRIO_MODE == PRIO_RR)
                rr_ptr <= (grant_idx == PW'(P-1)) ? '0 : grant_idx + PW'(1);
            for (int i = 0; i < P; i++) begin
                if (we_nx[i]) begin
                    ram_addr[i*ADDR_W +: ADDR_W]  <= src_addr[i*ADDR_W +: ADDR_W];
                    ram_wdata[i*DATA_W +: DATA_W] <= src_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_mp_ram_write_arbiter.sv
// Directed bench: a P=3 fixed-priority instance and a P=4 round-robin
// instance share the clock and reset.
module tb_mp_ram_write_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // P=3, fixed priority
    logic [2:0] a_req = '0;
    logic [5:0] a_addr = '0, a_data = '0;
    logic       a_busy, a_conf;
    logic [2:0] a_ack, a_we;
    logic [5:0] a_raddr, a_rdata;

    // P=4, round-robin
    logic [3:0] b_req = '0;
    logic [7:0] b_addr = '0, b_data = '0;
    logic       b_busy, b_conf;
    logic [3:0] b_ack, b_we;
    logic [7:0] b_raddr, b_rdata;

    mp_ram_write_arbiter #(.P(3), .ADDR_W(2), .DATA_W(2), .PRIO_MODE(0)) u_dut_a (
        .clk(clk), .rst(rst), .wr_req(a_req), .wr_addr(a_addr), .wr_data(a_data),
        .busy(a_busy), .wr_ack(a_ack), .conflict(a_conf),
        .ram_we(a_we), .ram_addr(a_raddr), .ram_wdata(a_rdata)
    );

    mp_ram_write_arbiter #(.P(4), .ADDR_W(2), .DATA_W(2), .PRIO_MODE(1)) u_dut_b (
        .clk(clk), .rst(rst), .wr_req(b_req), .wr_addr(b_addr), .wr_data(b_data),
        .busy(b_busy), .wr_ack(b_ack), .conflict(b_conf),
        .ram_we(b_we), .ram_addr(b_raddr), .ram_wdata(b_rdata)
    );

    int errors = 0;
    int checks = 0;
    logic [1:0] ram_a [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle; the RAM model absorbs instance A's writes.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            if (a_we[i]) ram_a[a_raddr[i*2 +: 2]] = a_rdata[i*2 +: 2];
    endtask

    task automatic chk_a(input string tag, input logic [2:0] we, input logic busy, input logic conf);
        chk({tag, ".we"},   32'(a_we),   32'(we));
        chk({tag, ".ack"},  32'(a_ack),  32'(we));
        chk({tag, ".busy"}, 32'(a_busy), 32'(busy));
        chk({tag, ".conf"}, 32'(a_conf), 32'(conf));
    endtask

    task automatic chk_b(input string tag, input logic [3:0] we, input logic busy, input logic conf);
        chk({tag, ".we"},   32'(b_we),   32'(we));
        chk({tag, ".ack"},  32'(b_ack),  32'(we));
        chk({tag, ".busy"}, 32'(b_busy), 32'(busy));
        chk({tag, ".conf"}, 32'(b_conf), 32'(conf));
    endtask

    initial begin
        for (int i = 0; i < 4; i++) ram_a[i] = '0;

        // reset
        tick(); tick();
        chk_a("rst_a", 3'b000, 1'b0, 1'b0);
        chk("rst_a.addr", 32'(a_raddr), 32'h0);
        chk("rst_a.data", 32'(a_rdata), 32'h0);
        chk_b("rst_b", 4'b0000, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_a("idle", 3'b000, 1'b0, 1'b0);

        // two ports, different addresses: straight through
        a_req = 3'b101; a_addr = 6'b11_00_01; a_data = 6'b01_00_10;
        tick();
        chk_a("nc", 3'b101, 1'b0, 1'b0);
        chk("nc.addr", 32'(a_raddr), 32'(6'b11_00_01));
        chk("nc.data", 32'(a_rdata), 32'(6'b01_00_10));
        a_req = '0;
        tick();
        chk_a("nc_off", 3'b000, 1'b0, 1'b0);

        // three-way conflict at A=2, data 0,1,2
        a_req = 3'b111; a_addr = 6'b10_10_10; a_data = 6'b10_01_00;
        tick();
        chk_a("c3.g0", 3'b001, 1'b1, 1'b1);
        a_req = '0;
        tick();
        chk_a("c3.g1", 3'b010, 1'b1, 1'b0);
        tick();
        chk_a("c3.g2", 3'b100, 1'b1, 1'b0);
        chk("c3.addr", 32'(a_raddr), 32'(6'b10_10_10));
        chk("c3.ram2", 32'(ram_a[2]), 32'd2);
        tick();
        chk_a("c3.end", 3'b000, 1'b0, 1'b0);

        // same address, same data: not a conflict
        a_req = 3'b011; a_addr = 6'b00_01_01; a_data = 6'b00_11_11;
        tick();
        chk_a("same", 3'b011, 1'b0, 1'b0);
        a_req = '0;
        tick();

        // requests during busy are ignored; held request is taken afterwards
        a_req = 3'b011; a_addr = 6'b00_00_00; a_data = 6'b00_01_00;
        tick();
        chk_a("bz.g0", 3'b001, 1'b1, 1'b1);
        a_req = 3'b010; a_addr = 6'b00_01_00; a_data = 6'b00_01_00;
        tick();
        chk_a("bz.g1", 3'b010, 1'b1, 1'b0);
        chk("bz.lat_addr", 32'(a_raddr[3:2]), 32'd0);
        tick();
        chk_a("bz.new", 3'b010, 1'b0, 1'b0);
        chk("bz.new_addr", 32'(a_raddr[3:2]), 32'd1);
        chk("bz.new_data", 32'(a_rdata[3:2]), 32'd1);
        a_req = '0;
        tick();

        // reset in the middle of serialisation
        a_req = 3'b111; a_addr = 6'b10_10_10; a_data = 6'b10_01_00;
        tick();
        chk_a("mr.g0", 3'b001, 1'b1, 1'b1);
        a_req = '0; rst = 1'b1;
        tick();
        chk_a("mr.rst", 3'b000, 1'b0, 1'b0);
        chk("mr.addr", 32'(a_raddr), 32'h0);
        chk("mr.data", 32'(a_rdata), 32'h0);
        rst = 1'b0;
        tick();
        chk_a("mr.after", 3'b000, 1'b0, 1'b0);
        tick();
        chk_a("mr.after2", 3'b000, 1'b0, 1'b0);

        // round-robin: ports 1,2,3 at A=0 from rr_ptr=0
        b_req = 4'b1110; b_addr = 8'h00; b_data = 8'b11_10_01_00;
        tick();
        chk_b("rr1.g0", 4'b0010, 1'b1, 1'b1);
        b_req = '0;
        tick();
        chk_b("rr1.g1", 4'b0100, 1'b1, 1'b0);
        tick();
        chk_b("rr1.g2", 4'b1000, 1'b1, 1'b0);
        chk("rr1.data", 32'(b_rdata[7:6]), 32'd3);
        tick();
        chk_b("rr1.end", 4'b0000, 1'b0, 1'b0);

        // ports 0,3 with rr_ptr back at 0
        b_req = 4'b1001; b_addr = 8'h00; b_data = 8'b10_00_00_01;
        tick();
        chk_b("rr2.g0", 4'b0001, 1'b1, 1'b1);
        b_req = '0;
        tick();
        chk_b("rr2.g1", 4'b1000, 1'b1, 1'b0);
        tick();

        // ports 0,2 leave rr_ptr at 3
        b_req = 4'b0101; b_addr = 8'h00; b_data = 8'b00_10_00_01;
        tick();
        chk_b("rr3.g0", 4'b0001, 1'b1, 1'b1);
        b_req = '0;
        tick();
        chk_b("rr3.g1", 4'b0100, 1'b1, 1'b0);
        tick();

        // ports 0,3 again: round-robin now starts at port 3
        b_req = 4'b1001; b_addr = 8'h00; b_data = 8'b10_00_00_01;
        tick();
        chk_b("rr4.g0", 4'b1000, 1'b1, 1'b1);
        b_req = '0;
        tick();
        chk_b("rr4.g1", 4'b0001, 1'b1, 1'b0);
        tick();
        chk_b("rr4.end", 4'b0000, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
